// File: rtl/io_output_reg_pkg.sv
// io_output_reg_pkg: shared IO address map for the input and output port blocks
//   io_idx_t         word index taken from addr[7:2]
//   IO_OUT_BASE_IDX  output port 0 index; port i sits at base + i
//   IO_STATUS_IDX    output status word (valid / overflow flags)
//   IO_IN_PORT*_IDX  input-side port indices, kept here so both sides share one map
package io_output_reg_pkg;
    typedef logic [5:0] io_idx_t;
    localparam io_idx_t IO_OUT_BASE_IDX = 6'b100000;
    localparam io_idx_t IO_STATUS_IDX = 6'b100111;
    localparam int STATUS_OVF_LSB = 8;
    localparam io_idx_t IO_IN_PORT0_IDX = 6'b110000;
    localparam io_idx_t IO_IN_PORT1_IDX = 6'b110001;
    function automatic io_idx_t port_idx(input int i);
        return IO_OUT_BASE_IDX + io_idx_t'(i);
    endfunction
endpackage

// File: rtl/io_output_reg_if.sv
// io_output_reg_if: CPU-side IO bus between the load/store path and the output port block
//   addr             byte address (only [7:2] decoded by the block)
//   datain           store data
//   write_io_enable  store strobe, already qualified by IO-space decode
//   io_read_data     combinational readback to the load-data mux
interface io_output_reg_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [31:0] io_read_data;
    modport master (output addr, datain, write_io_enable, input io_read_data);
    modport slave (input addr, datain, write_io_enable, output io_read_data);
endinterface

// File: rtl/io_output_reg_mux.sv
// io_output_mux: combinational readback select for the output port block
//   idx    word index from addr[7:2]
//   port   flattened port registers, port i at [i*DATA_W +: DATA_W]
//   valid  per-port pending flags
//   ovf    per-port sticky overflow flags
//   rd     selected word; zero for unmapped indices
module io_output_mux
    import io_output_reg_pkg::*;
#(
    parameter int N_PORTS = 3,
    parameter int DATA_W  = 32
) (
    input  io_idx_t                     idx,
    input  logic [N_PORTS*DATA_W-1:0]   port,
    input  logic [N_PORTS-1:0]          valid,
    input  logic [N_PORTS-1:0]          ovf,
    output logic [31:0]                 rd
);
    always_comb begin
        rd = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (idx == port_idx(i)) rd = 32'(port[i*DATA_W +: DATA_W]);
        // With 8 ports the last port index aliases STATUS; STATUS wins
        if (idx == IO_STATUS_IDX) begin
            rd = '0;
            rd[N_PORTS-1:0] = valid;
            rd[STATUS_OVF_LSB +: N_PORTS] = ovf;
        end
    end
endmodule

// File: rtl/io_output_reg.sv
// io_output_reg: memory-mapped output ports with valid/ack handshake and sticky overflow
//   io_clk     IO clock
//   resetn     asynchronous active-low reset
//   bus        CPU IO bus (slave side)
//   out_port   port registers, port i at [i*DATA_W +: DATA_W]
//   out_valid  port i holds data not yet acknowledged
//   out_ack    peripheral consumes port i
module io_output_reg
    import io_output_reg_pkg::*;
#(
    parameter int N_PORTS = 3,
    parameter int DATA_W  = 32
) (
    input  logic                        io_clk,
    input  logic                        resetn,
    io_output_reg_if.slave              bus,
    output logic [N_PORTS*DATA_W-1:0]   out_port,
    output logic [N_PORTS-1:0]          out_valid,
    input  logic [N_PORTS-1:0]          out_ack
);
    io_idx_t            idx;
    logic               sts_wr;
    logic [N_PORTS-1:0] ovf;

    assign idx    = bus.addr[7:2];
    assign sts_wr = bus.write_io_enable && idx == IO_STATUS_IDX;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        logic wr;
        assign wr = bus.write_io_enable && idx == port_idx(i) && idx != IO_STATUS_IDX;
        always_ff @(posedge io_clk or negedge resetn) begin
            if (!resetn) begin
                out_port[i*DATA_W +: DATA_W] <= '0;
                out_valid[i]                 <= 1'b0;
                ovf[i]                       <= 1'b0;
            end else begin
                if (wr) out_port[i*DATA_W +: DATA_W] <= bus.datain[DATA_W-1:0];
                // A write wins over a same-edge ack, so fresh data stays pending
                out_valid[i] <= wr ? 1'b1 : out_valid[i] && !out_ack[i];
                // Overwriting unacknowledged data is sticky until W1C via STATUS
                if (wr && out_valid[i] && !out_ack[i]) ovf[i] <= 1'b1;
                else if (sts_wr && bus.datain[STATUS_OVF_LSB+i]) ovf[i] <= 1'b0;
            end
        end
    end

    io_output_mux #(.N_PORTS(N_PORTS), .DATA_W(DATA_W)) u_mux (
        .idx   (idx),
        .port  (out_port),
        .valid (out_valid),
        .ovf   (ovf),
        .rd    (bus.io_read_data)
    );
endmodule

// File: tb/tb_io_output_reg.sv
// tb_io_output_reg: directed self-checking bench for io_output_reg
module tb_io_output_reg;
    logic        io_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [95:0] out_port;
    logic [2:0]  out_valid;
    logic [2:0]  out_ack = '0;
    logic [31:0] r;
    int          checks = 0;
    int          errors = 0;

    io_output_reg_if bus ();

    io_output_reg #(.N_PORTS(3), .DATA_W(32)) dut (
        .io_clk    (io_clk),
        .resetn    (resetn),
        .bus       (bus),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ack   (out_ack)
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ack);
        @(negedge io_clk);
        bus.addr = a;
        bus.datain = d;
        bus.write_io_enable = 1'b1;
        out_ack = ack;
        @(posedge io_clk);
        #1;
        bus.write_io_enable = 1'b0;
        out_ack = '0;
    endtask

    task automatic ack(input logic [2:0] v);
        @(negedge io_clk);
        out_ack = v;
        @(posedge io_clk);
        #1;
        out_ack = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.io_read_data;
    endtask

    initial begin
        bus.addr = '0;
        bus.datain = '0;
        bus.write_io_enable = 1'b0;
        repeat (3) @(posedge io_clk);
        #1;
        check("rst_port", out_port, '0);
        check("rst_valid", {93'b0, out_valid}, '0);
        rd(32'h9C, r); check("rst_status", {64'b0, r}, '0);
        @(negedge io_clk);
        resetn = 1'b1;

        sw(32'h80, 32'h0000_00A5, 3'b000);
        check("wr0_port0", {64'b0, out_port[31:0]}, 96'hA5);
        check("wr0_valid", {93'b0, out_valid}, 96'h1);
        rd(32'h9C, r); check("wr0_status", {64'b0, r}, 96'h1);

        ack(3'b001);
        check("ack0_valid", {93'b0, out_valid}, '0);
        rd(32'h80, r); check("ack0_read80", {64'b0, r}, 96'hA5);
        rd(32'h9C, r); check("ack0_status", {64'b0, r}, '0);

        ack(3'b001);
        check("idle_ack_valid", {93'b0, out_valid}, '0);

        sw(32'h84, 32'h1, 3'b000);
        sw(32'h84, 32'h2, 3'b000);
        check("ovf_port1", {64'b0, out_port[63:32]}, 96'h2);
        check("ovf_valid", {93'b0, out_valid}, 96'h2);
        rd(32'h9C, r); check("ovf_status", {64'b0, r}, 96'h202);

        sw(32'h9C, 32'h200, 3'b000);
        rd(32'h9C, r); check("w1c_status", {64'b0, r}, 96'h2);
        check("w1c_port1", {64'b0, out_port[63:32]}, 96'h2);

        sw(32'h88, 32'h5, 3'b000);
        sw(32'h88, 32'h7, 3'b100);
        check("wrack_port2", {64'b0, out_port[95:64]}, 96'h7);
        check("wrack_valid", {93'b0, out_valid}, 96'h6);
        rd(32'h9C, r); check("wrack_status", {64'b0, r}, 96'h6);

        @(negedge io_clk);
        bus.addr = 32'h80;
        bus.datain = 32'hDEAD_BEEF;
        @(posedge io_clk);
        #1;
        check("noen_port", out_port, {32'h7, 32'h2, 32'hA5});

        sw(32'h90, 32'hFFFF_FFFF, 3'b000);
        sw(32'hC0, 32'h1234, 3'b000);
        sw(32'h8C, 32'h5678, 3'b000);
        check("unmap_port", out_port, {32'h7, 32'h2, 32'hA5});
        check("unmap_valid", {93'b0, out_valid}, 96'h6);
        rd(32'h90, r); check("unmap_read90", {64'b0, r}, '0);
        rd(32'hC0, r); check("unmap_readC0", {64'b0, r}, '0);
        rd(32'h8C, r); check("unmap_read8C", {64'b0, r}, '0);
        rd(32'h9C, r); check("unmap_status", {64'b0, r}, 96'h6);

        sw(32'hFFFF_FF81, 32'h33, 3'b000);
        check("alias_port0", {64'b0, out_port[31:0]}, 96'h33);
        rd(32'h9C, r); check("alias_status", {64'b0, r}, 96'h7);

        sw(32'h84, 32'h3, 3'b000);
        rd(32'h9C, r); check("pre_rst_status", {64'b0, r}, 96'h207);

        #2;
        resetn = 1'b0;
        #1;
        check("arst_port", out_port, '0);
        check("arst_valid", {93'b0, out_valid}, '0);
        rd(32'h9C, r); check("arst_status", {64'b0, r}, '0);

        out_ack = 3'b111;
        @(negedge io_clk);
        resetn = 1'b1;
        @(posedge io_clk);
        #1;
        out_ack = '0;
        check("post_rst_valid", {93'b0, out_valid}, '0);
        rd(32'h9C, r); check("post_rst_status", {64'b0, r}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
